// File: rtl/seq_mult_54x54.sv
// 54x54 unsigned multiplier that time-shares one external 27x27 multiplier.
// Issues four partial-product pairs and shift-accumulates the returns into 108 bits.
module seq_mult_54x54 #(
    parameter int MUL_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [53:0]  a,
    input  logic [53:0]  b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [107:0] product,
    output logic [26:0]  mul_a,
    output logic [26:0]  mul_b,
    input  logic [53:0]  mul_y
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t       state, state_nxt;
    logic [1:0]   step;
    logic [53:0]  a_q, b_q;
    logic [107:0] acc, addend, acc_sum;
    logic         accept, issue_vld, ret_vld;
    logic [1:0]   ret_step;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   if (step == 2'd3) state_nxt = (MUL_LAT == 0) ? DONE : DRAIN;
            DRAIN:   if (ret_vld && ret_step == 2'd3) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        issue_vld = (state == ISSUE);
        mul_a     = '0;
        mul_b     = '0;
        if (state == ISSUE) begin
            case (step)
                2'd0:    begin mul_a = a_q[26:0];  mul_b = b_q[26:0];  end
                2'd1:    begin mul_a = a_q[26:0];  mul_b = b_q[53:27]; end
                2'd2:    begin mul_a = a_q[53:27]; mul_b = b_q[26:0];  end
                default: begin mul_a = a_q[53:27]; mul_b = b_q[53:27]; end
            endcase
        end
    end

    // Tag pipe mirrors the external multiplier latency so each return knows its shift.
    generate
        if (MUL_LAT == 0) begin : g_no_pipe
            assign ret_vld  = issue_vld;
            assign ret_step = step;
        end else begin : g_pipe
            logic [MUL_LAT-1:0]      vld_pipe;
            logic [MUL_LAT-1:0][1:0] step_pipe;
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_pipe  <= '0;
                    step_pipe <= '0;
                end else begin
                    vld_pipe[0]  <= issue_vld;
                    step_pipe[0] <= step;
                    for (int i = 1; i < MUL_LAT; i++) begin
                        vld_pipe[i]  <= vld_pipe[i-1];
                        step_pipe[i] <= step_pipe[i-1];
                    end
                end
            end
            assign ret_vld  = vld_pipe[MUL_LAT-1];
            assign ret_step = step_pipe[MUL_LAT-1];
        end
    endgenerate

    always_comb begin
        case (ret_step)
            2'd0:       addend = {54'd0, mul_y};
            2'd1, 2'd2: addend = {54'd0, mul_y} << 27;
            default:    addend = {54'd0, mul_y} << 54;
        endcase
        acc_sum = acc + addend;
    end

    // product only moves on the final return, so it holds through DONE and after the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            product <= '0;
            step    <= '0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            acc  <= '0;
            step <= '0;
        end else begin
            if (issue_vld) step <= step + 2'd1;
            if (ret_vld) begin
                acc <= acc_sum;
                if (ret_step == 2'd3) product <= acc_sum;
            end
        end
    end
endmodule
